// File: rtl/config_loader_pkg.sv
// Shared definitions for config_loader: default geometry and the FSM state encoding.
// The CHECK state exists only when CONFIG_LOADER_CHECKSUM_EN is defined.
package config_loader_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 31;
  localparam int STATE_W       = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_WORD = 3'd1;
  localparam state_t ST_SETUP     = 3'd2;
  localparam state_t ST_STROBE    = 3'd3;
  localparam state_t ST_HOLD      = 3'd4;
  localparam state_t ST_DONE      = 3'd5;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam state_t ST_CHECK     = 3'd6;
`endif

  // A load is in flight in every state except the two resting ones.
  function automatic logic state_busy(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/config_loader.sv
// Streams NUM_WORDS configuration words into a latch bank: each word is put on io_d_out,
// then one enable strobes with a quiet cycle either side. Optional checksum: CONFIG_LOADER_CHECKSUM_EN.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_data,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
`ifdef CONFIG_LOADER_CHECKSUM_EN
  output logic                 io_error,
`endif
  output logic                 io_done
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // Word stream: a word moves when io_in_valid && io_in_ready on a rising clk edge.
  // io_in_ready depends only on the state register, never on io_in_valid.
  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [WORD_W-1:0]      d_out;
  logic [NUM_WORDS-1:0]   en;
  logic                   done;
  logic                   handshake;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]      acc;
  logic                   error;
`endif

`ifdef CONFIG_LOADER_CHECKSUM_EN
  assign io_in_ready = (state == ST_WAIT_WORD) || (state == ST_CHECK);
  assign io_error    = error;
`else
  assign io_in_ready = (state == ST_WAIT_WORD);
`endif
  assign handshake     = io_in_valid && io_in_ready;
  assign io_d_out      = d_out;
  assign io_configs_en = en;
  assign io_busy       = state_busy(state);
  assign io_done       = done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      d_out <= '0;
      en    <= '0;
      done  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      acc   <= '0;
      error <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (io_start) begin
            done  <= 1'b0;
            idx   <= '0;
            state <= ST_WAIT_WORD;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            acc   <= '0;
            error <= 1'b0;
`endif
          end
        end
        ST_WAIT_WORD: begin
          if (handshake) begin
            d_out <= io_in_data;
            state <= ST_SETUP;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            acc   <= acc ^ io_in_data;
`endif
          end
        end
        ST_SETUP: begin
          // io_d_out has settled for a full cycle before the enable rises.
          en    <= NUM_WORDS'(1) << idx;
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          en    <= '0;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (idx == LAST_IDX) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
            state <= ST_CHECK;
`else
            done  <= 1'b1;
            state <= ST_DONE;
`endif
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_WAIT_WORD;
          end
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          // The trailing word is the expected XOR of the whole load; it never reaches io_d_out.
          if (handshake) begin
            error <= (io_in_data != acc);
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
